// File: rtl/eth_pcs_params.sv
// ============================================================================
// Package     : eth_pcs_params
// Description : Shared widths and constants for the 10GBASE-R PCS gearboxes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_pcs_params;

   localparam int unsigned W_DATA           = 32;
   localparam int unsigned W_SYNC           = 2;
   localparam int unsigned W_TX_GEARBOX_CNT = 7;
   localparam int unsigned W_TX_GEARBOX_RES = 64;

   localparam logic [W_TX_GEARBOX_CNT-1:0] TX_GEARBOX_CNT = 7'd65;

   // Bits held over in the residue at a given sequence count. This value is
   // always derived from the counter and is never stored.
   function automatic logic [W_TX_GEARBOX_CNT-1:0] f_residue_bits(
      input logic [W_TX_GEARBOX_CNT-1:0] cnt
   );
      if (cnt == TX_GEARBOX_CNT) begin
         return W_TX_GEARBOX_CNT'(W_DATA);
      end
      return cnt + {{(W_TX_GEARBOX_CNT-1){1'b0}}, cnt[0]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/eth_pcs_tx_gearbox.sv
// ============================================================================
// Module      : eth_pcs_tx_gearbox
// Description : 10GBASE-R TX gearbox, 66b blocks (two 32b halves) -> 32b PMA words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_pcs_tx_gearbox
   import eth_pcs_params::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_hdr_valid,
   input  logic [W_SYNC-1:0] i_hdr,
   input  logic [W_DATA-1:0] i_data,
   output logic              o_grbx_ready,
   output logic [W_DATA-1:0] o_pma_data,
   output logic              o_seq_err
);

   // Widest merge is 34 input bits landing at residue offset 62 (or 32 at 64),
   // so 96 bits hold every combination without loss.
   localparam int unsigned c_W_COMB = W_DATA + W_TX_GEARBOX_RES;

   logic [W_TX_GEARBOX_CNT-1:0] r_seq_cnt;
   logic [W_TX_GEARBOX_RES-1:0] r_residue;

   logic [W_TX_GEARBOX_CNT-1:0] w_seq_cnt_nxt;
   logic                        w_ready;
   logic                        w_first_half;
   logic                        w_seq_err;
   logic [W_TX_GEARBOX_CNT-1:0] w_res_bits;
   logic [c_W_COMB-1:0]         w_in_bits;
   logic [c_W_COMB-1:0]         w_comb;

   always_comb begin : p_seq
      w_seq_cnt_nxt = r_seq_cnt + W_TX_GEARBOX_CNT'(1);
      if (r_seq_cnt == TX_GEARBOX_CNT) begin
         w_seq_cnt_nxt = '0;
      end
      w_ready      = (r_seq_cnt < (TX_GEARBOX_CNT - W_TX_GEARBOX_CNT'(1)));
      w_first_half = ~r_seq_cnt[0];
      w_seq_err    = w_ready & (i_hdr_valid != w_first_half);
   end

   always_comb begin : p_merge
      w_res_bits = f_residue_bits(r_seq_cnt);
      w_in_bits  = '0;
      if (w_ready) begin
         if (w_first_half) begin
            w_in_bits = c_W_COMB'({i_data, i_hdr});
         end else begin
            w_in_bits = c_W_COMB'(i_data);
         end
      end
      w_comb = c_W_COMB'(r_residue) | (w_in_bits << w_res_bits);
   end

   assign o_grbx_ready = w_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_seq_cnt  <= '0;
         r_residue  <= '0;
         o_pma_data <= '0;
         o_seq_err  <= 1'b0;
      end else begin
         r_seq_cnt  <= w_seq_cnt_nxt;
         r_residue  <= w_comb[c_W_COMB-1:W_DATA];
         o_pma_data <= w_comb[W_DATA-1:0];
         o_seq_err  <= w_seq_err;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_eth_pcs_tx_gearbox.sv
// ============================================================================
// Module      : tb_eth_pcs_tx_gearbox
// Description : Directed self-checking bench for the 66b->32b TX gearbox.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_pcs_tx_gearbox;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_hdr_valid;
   logic [1:0]  i_hdr;
   logic [31:0] i_data;
   logic        o_grbx_ready;
   logic [31:0] o_pma_data;
   logic        o_seq_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          tb_cnt   = 0;
   int          n_ready_seen = 0;
   int          n_err_pulses = 0;
   bit          q_bits[$];
   logic [1:0]  blk_hdr;
   logic [63:0] blk_data;

   eth_pcs_tx_gearbox u_dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_hdr_valid  (i_hdr_valid),
      .i_hdr        (i_hdr),
      .i_data       (i_data),
      .o_grbx_ready (o_grbx_ready),
      .o_pma_data   (o_pma_data),
      .o_seq_err    (o_seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: present inputs, update the bit-stream model, check outputs.
   task automatic step(input logic hv, input logic [1:0] hdr, input logic [31:0] d);
      logic        rdy_exp;
      logic        err_exp;
      logic [31:0] d_exp;
      i_hdr_valid = hv;
      i_hdr       = hdr;
      i_data      = d;
      rdy_exp     = (tb_cnt < 64);
      chk("ready", 32'(o_grbx_ready), 32'(rdy_exp));
      if (o_grbx_ready) n_ready_seen++;
      if (rdy_exp) begin
         if (tb_cnt % 2 == 0) begin
            q_bits.push_back(hdr[0]);
            q_bits.push_back(hdr[1]);
         end
         for (int i = 0; i < 32; i++) q_bits.push_back(d[i]);
      end
      err_exp = rdy_exp && (hv != (tb_cnt % 2 == 0));
      @(posedge clk);
      #1;
      d_exp = '0;
      for (int i = 0; i < 32; i++) begin
         if (q_bits.size() > 0) d_exp[i] = q_bits.pop_front();
      end
      chk("pma_data", o_pma_data, d_exp);
      chk("seq_err", 32'(o_seq_err), 32'(err_exp));
      if (o_seq_err) n_err_pulses++;
      tb_cnt = (tb_cnt == 65) ? 0 : tb_cnt + 1;
   endtask

   // Random blocks in phase; idle cycles get garbage that must be ignored.
   // bad_at selects one cycle whose hdr_valid is inverted (-1 = none).
   task automatic run_blocks(input int ncyc, input int bad_at);
      logic [31:0] rnd;
      logic [31:0] rnd2;
      for (int k = 0; k < ncyc; k++) begin
         rnd  = $urandom;
         rnd2 = $urandom;
         if (tb_cnt < 64 && tb_cnt % 2 == 0) begin
            blk_hdr  = rnd[0] ? 2'b10 : 2'b01;
            blk_data = {$urandom, $urandom};
            step((k == bad_at) ? 1'b0 : 1'b1, blk_hdr, blk_data[31:0]);
         end else if (tb_cnt < 64) begin
            step((k == bad_at) ? 1'b1 : 1'b0, rnd[2:1], blk_data[63:32]);
         end else begin
            step(rnd[3], rnd[5:4], rnd2);
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      i_hdr_valid = 1'b0;
      i_hdr       = 2'b00;
      i_data      = '0;
      #1;
      chk("rst_pma_data", o_pma_data, 32'h0);
      chk("rst_seq_err", 32'(o_seq_err), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", 32'(o_grbx_ready), 32'h1);

      // Hand-computed first block.
      step(1'b1, 2'b10, 32'h0000_0000);
      chk("blk1_word0", o_pma_data, 32'h0000_0002);
      step(1'b0, 2'b00, 32'hFFFF_FFFF);
      chk("blk1_word1", o_pma_data, 32'hFFFF_FFFC);
      run_blocks(64, -1);

      // Free-run: 3 full periods then 2 extra cycles.
      n_ready_seen = 0;
      run_blocks(198, -1);
      chk("ready_per_3_periods", 32'(n_ready_seen), 32'd192);
      run_blocks(2, -1);

      // Realign to cnt 0, then one period of 32 random blocks with drain.
      run_blocks(64, -1);
      chk("period_start", 32'(tb_cnt), 32'd0);
      run_blocks(66, -1);

      // Header-valid on a second-half cycle.
      n_err_pulses = 0;
      run_blocks(66, 5);
      chk("seq_err_pulses_odd", 32'(n_err_pulses), 32'd1);
      n_err_pulses = 0;
      run_blocks(66, 10);
      chk("seq_err_pulses_even", 32'(n_err_pulses), 32'd1);

      // Reset at cnt 37 for one cycle.
      run_blocks(37, -1);
      rst = 1'b1;
      #1;
      chk("midrst_pma_data", o_pma_data, 32'h0);
      chk("midrst_ready", 32'(o_grbx_ready), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_bits.delete();
      tb_cnt = 0;
      chk("midrst_seq_err", 32'(o_seq_err), 32'h0);
      step(1'b1, 2'b01, 32'h8000_0001);
      chk("postrst_word0", o_pma_data, 32'h0000_0005);
      step(1'b0, 2'b00, 32'h0000_0003);
      chk("postrst_word1", o_pma_data, 32'h0000_000E);
      run_blocks(64, -1);
      run_blocks(66, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
